// File: rtl/mem_access_stage_pkg.sv
// MEM stage shared types: widths, FSM encoding and the MEM/WB bundle.
// Imported by the MEM/WB register and the MEM stage top.
package mem_access_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef struct packed {
    logic              memtoreg;
    logic              regwrite;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_W-1:0]  write_reg;
  } mem_wb_t;

endpackage

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register with load enable and bubble insert.
// A bubble clears the whole bundle so WB sees no write.
module mem_wb_reg
  import mem_access_stage_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  logic    bubble,
  input  mem_wb_t d,
  output mem_wb_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= bubble ? '0 : d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory req/ack access FSM, stall generation
// and the MEM/WB pipeline register feeding WB.
module mem_access_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_valid,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  input  logic              MEM_MemtoReg,
  input  logic              MEM_RegWrite,
  input  logic [DATA_W-1:0] MEM_alu_result,
  input  logic [DATA_W-1:0] MEM_write_data,
  input  logic [REG_W-1:0]  MEM_write_reg,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_stall,
  output logic              misalign_err,
  output logic              WB_MemtoReg,
  output logic              WB_RegWrite_in,
  output logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] alu_result,
  output logic [REG_W-1:0]  write_reg_to_wb
);

  mem_access_stage_pkg::state_t  state, next_state;
  mem_access_stage_pkg::mem_wb_t wb_d, wb_q;

  logic             wb_bubble;
  logic             memop;
  logic             aligned;
  logic             accept;
  logic             cap_memtoreg;
  logic             cap_regwrite;
  logic             cap_load;
  logic [REG_W-1:0] cap_write_reg;

  assign memop   = MEM_valid & (MEM_MemRead | MEM_MemWrite);
  assign aligned = (MEM_alu_result[1:0] == 2'b00);
  assign accept  = (state == mem_access_stage_pkg::IDLE)
                 & memop & aligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= mem_access_stage_pkg::IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Request fields are frozen at accept so memory sees them stable until ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      cap_memtoreg  <= 1'b0;
      cap_regwrite  <= 1'b0;
      cap_load      <= 1'b0;
      cap_write_reg <= '0;
      misalign_err  <= 1'b0;
    end else begin
      misalign_err <= (state == mem_access_stage_pkg::IDLE)
                    & memop & ~aligned;
      if (accept) begin
        dmem_req      <= 1'b1;
        dmem_we       <= MEM_MemWrite;
        dmem_addr     <= MEM_alu_result;
        dmem_wdata    <= MEM_write_data;
        cap_memtoreg  <= MEM_MemtoReg;
        cap_regwrite  <= MEM_RegWrite;
        cap_load      <= MEM_MemRead & ~MEM_MemWrite;
        cap_write_reg <= MEM_write_reg;
      end else if (state == mem_access_stage_pkg::ACCESS && dmem_ack) begin
        dmem_req <= 1'b0;
      end
    end
  end

  always_comb begin
    next_state = state;
    mem_stall  = 1'b0;
    wb_bubble  = 1'b1;
    wb_d       = '0;
    unique case (state)
      mem_access_stage_pkg::IDLE: begin
        if (memop && aligned) begin
          mem_stall  = 1'b1;
          next_state = mem_access_stage_pkg::ACCESS;
        end else if (!memop) begin
          wb_bubble       = 1'b0;
          wb_d.memtoreg   = MEM_MemtoReg;
          wb_d.regwrite   = MEM_RegWrite & MEM_valid;
          wb_d.alu_result = MEM_alu_result;
          wb_d.write_reg  = MEM_write_reg;
        end
      end
      mem_access_stage_pkg::ACCESS: begin
        mem_stall = ~dmem_ack;
        if (dmem_ack) begin
          next_state      = mem_access_stage_pkg::IDLE;
          wb_bubble       = 1'b0;
          wb_d.memtoreg   = cap_memtoreg;
          wb_d.regwrite   = cap_regwrite;
          wb_d.read_data  = cap_load ? dmem_rdata : '0;
          wb_d.alu_result = dmem_addr;
          wb_d.write_reg  = cap_write_reg;
        end
      end
      default: next_state = mem_access_stage_pkg::IDLE;
    endcase
  end

  mem_wb_reg u_mem_wb_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (1'b1),
    .bubble (wb_bubble),
    .d      (wb_d),
    .q      (wb_q)
  );

  assign WB_MemtoReg     = wb_q.memtoreg;
  assign WB_RegWrite_in  = wb_q.regwrite;
  assign read_data       = wb_q.read_data;
  assign alu_result      = wb_q.alu_result;
  assign write_reg_to_wb = wb_q.write_reg;

endmodule
